sync_countdown_timer: RTL and testbench

//  Loadable synchronous down-counter with a control FSM. It produces a one-cycle expiry pulse

---
 rtl/sync_countdown_timer.sv | 134 +++++++++++++
 tb/tb_sync_countdown_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_countdown_timer.sv
// sync_countdown_timer
//   Loadable synchronous down-counter with a small control FSM. After a
//   programmed number of enabled cycles it emits a one-cycle expiry pulse.
//   Used as the timeout/delay generator for bus handshakes and peripheral
//   timers (UART bit timing, watchdog).
//
//   Optional feature macro: TIMER_AUTO_RELOAD_EN
//     defined   : at expiry the counter reloads from period and keeps running,
//                 producing a periodic expiry pulse (period==0 at reload -> DONE).
//     undefined : at expiry the timer parks in DONE with value=0.
//
// Parameters
//   size        width of period/value
//   init_value  value driven after reset and after abort
//
// Ports
//   clock    in   1     rising-edge clock
//   reset    in   1     synchronous, active-high reset
//   start    in   1     load period and run (restarts while running)
//   abort    in   1     stop immediately, return to IDLE
//   hold     in   1     freeze the count while in RUN
//   period   in   size  cycles until expiry, sampled on start (and on reload)
//   value    out  size  current count (registered)
//   running  out  1     high while in RUN
//   expired  out  1     one-cycle pulse when the count reaches 0
//   done     out  1     level, high while in DONE
//
// State table
//   state | meaning
//   IDLE  | not counting, value = init_value
//   RUN   | counting down, value >= 1
//   DONE  | count reached zero, waiting for start/abort/reset

module sync_countdown_timer #(
  parameter int unsigned         size       = 8,
  parameter logic [size-1:0]     init_value = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [size-1:0] period,
  output logic [size-1:0] value,
  output logic            running,
  output logic            expired,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};

  state_t state;
  logic   period_zero;
  logic   terminal;

  assign period_zero = (period == '0);
  // Treating value<=1 as terminal keeps the counter from ever wrapping below 0.
  assign terminal    = (value <= ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      value   <= init_value;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        value   <= init_value;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (start) begin
        // A zero period expires immediately rather than counting 2^size cycles.
        if (period_zero) begin
          state   <= DONE;
          value   <= '0;
          running <= 1'b0;
          done    <= 1'b1;
          expired <= 1'b1;
        end else begin
          state   <= RUN;
          value   <= period;
          running <= 1'b1;
          done    <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (!hold) begin
              if (!terminal) begin
                value <= value - ONE;
              end else begin
                expired <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                if (period_zero) begin
                  state   <= DONE;
                  value   <= '0;
                  running <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  value <= period;
                end
`else
                state   <= DONE;
                value   <= '0;
                running <= 1'b0;
                done    <= 1'b1;
`endif
              end
            end
          end
          IDLE, DONE: begin
            // hold is ignored outside RUN; outputs keep their values.
          end
          default: begin
            state   <= IDLE;
            value   <= init_value;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_countdown_timer.sv
// Testbench for sync_countdown_timer: directed scenarios plus a randomized
// run against a behavioural reference model. Build with +define+TIMER_AUTO_RELOAD_EN
// to exercise the auto-reload variant.

module tb_sync_countdown_timer;

  localparam int SIZE = 8;

  logic            clock;
  logic            reset;
  logic            start;
  logic            abort;
  logic            hold;
  logic [SIZE-1:0] period;
  logic [SIZE-1:0] value;
  logic            running;
  logic            expired;
  logic            done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0=idle, 1=counting, 2=finished.
  int m_mode;
  int m_val;
  bit m_exp;

  sync_countdown_timer #(.size(SIZE), .init_value('0)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .hold    (hold),
    .period  (period),
    .value   (value),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply inputs, let one rising edge happen, return 1 time unit after it.
  task automatic step(input bit r, input bit s, input bit a, input bit h, input int p);
    reset  = r;
    start  = s;
    abort  = a;
    hold   = h;
    period = p[SIZE-1:0];
    @(posedge clock);
    #1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit a, input bit h, input int p);
    m_exp = 1'b0;
    if (r) begin
      m_mode = 0; m_val = 0;
    end else if (a) begin
      m_mode = 0; m_val = 0;
    end else if (s) begin
      if (p == 0) begin
        m_mode = 2; m_val = 0; m_exp = 1'b1;
      end else begin
        m_mode = 1; m_val = p;
      end
    end else if (m_mode == 1 && !h) begin
      if (m_val - 1 > 0) begin
        m_val = m_val - 1;
      end else begin
        m_exp = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
        if (p != 0) m_val = p;
        else begin m_mode = 2; m_val = 0; end
`else
        m_mode = 2; m_val = 0;
`endif
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
    n_checks++; if (value !== 8'd0) $display("FAIL reset_value got=%0d exp=0", value); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else n_pass++;
    n_checks++; if (expired !== 1'b0) $display("FAIL reset_expired got=%b exp=0", expired); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    int exp_seq[4] = '{3, 2, 1, 0};
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(0, 0, 0, 0, 3);
`ifdef TIMER_AUTO_RELOAD_EN
      if (i == 3) begin
        n_checks++; if (value !== 8'd3) $display("FAIL basic_reload_value got=%0d exp=3", value); else n_pass++;
      end else begin
        n_checks++; if (value !== 8'(exp_seq[i])) $display("FAIL basic_value[%0d] got=%0d exp=%0d", i, value, exp_seq[i]); else n_pass++;
      end
`else
      n_checks++; if (value !== 8'(exp_seq[i])) $display("FAIL basic_value[%0d] got=%0d exp=%0d", i, value, exp_seq[i]); else n_pass++;
`endif
      n_checks++; if (expired !== (i == 3)) $display("FAIL basic_expired[%0d] got=%b exp=%b", i, expired, (i == 3)); else n_pass++;
    end
`ifndef TIMER_AUTO_RELOAD_EN
    n_checks++; if (done !== 1'b1 || running !== 1'b0) $display("FAIL basic_done got done=%b running=%b exp done=1 running=0", done, running); else n_pass++;
    step(0, 0, 0, 0, 3);
    n_checks++; if (expired !== 1'b0 || done !== 1'b1) $display("FAIL basic_after got expired=%b done=%b exp 0/1", expired, done); else n_pass++;
`endif
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_hold();
    int edges = -1;
    step(0, 1, 0, 0, 5);
    step(0, 0, 0, 0, 5);
    step(0, 0, 0, 1, 5);
    step(0, 0, 0, 1, 5);
    n_checks++; if (value !== 8'd4) $display("FAIL hold_frozen got=%0d exp=4", value); else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 0, 5);
      if (expired === 1'b1) begin edges = 3 + i; break; end
    end
    n_checks++; if (edges !== 7) $display("FAIL hold_expiry_edges got=%0d exp=7", edges); else n_pass++;
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_restart_abort();
    int pulses = 0;
    step(0, 1, 0, 0, 4);
    step(0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 4);
    n_checks++; if (value !== 8'd2) $display("FAIL restart_pre got=%0d exp=2", value); else n_pass++;
    step(0, 1, 0, 1, 6);
    n_checks++; if (value !== 8'd6 || running !== 1'b1) $display("FAIL restart_load got value=%0d running=%b exp 6/1", value, running); else n_pass++;
    step(0, 1, 1, 0, 9);
    n_checks++; if (value !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0)
      $display("FAIL abort_state got value=%0d running=%b done=%b expired=%b exp 0/0/0/0", value, running, done, expired);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1'($urandom), 6);
      if (expired === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0 || value !== 8'd0) $display("FAIL abort_quiet got pulses=%0d value=%0d exp 0/0", pulses, value); else n_pass++;
  endtask

  task automatic test_period_zero();
    step(0, 1, 0, 0, 0);
    n_checks++; if (expired !== 1'b1 || done !== 1'b1 || value !== 8'd0 || running !== 1'b0)
      $display("FAIL zero_immediate got expired=%b done=%b value=%0d running=%b exp 1/1/0/0", expired, done, value, running);
    else n_pass++;
    step(0, 0, 0, 1, 0);
    n_checks++; if (expired !== 1'b0 || done !== 1'b1) $display("FAIL zero_single_pulse got expired=%b done=%b exp 0/1", expired, done); else n_pass++;
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_max();
    int edges = -1;
    int bad   = 0;
    int prev;
    step(0, 1, 0, 0, 255);
    n_checks++; if (value !== 8'd255) $display("FAIL max_load got=%0d exp=255", value); else n_pass++;
    prev = 255;
    for (int i = 1; i <= 300; i++) begin
      step(0, 0, 0, 0, 255);
      if (expired === 1'b1) begin edges = i; break; end
      if (int'(value) != prev - 1) bad++;
      prev = int'(value);
    end
    n_checks++; if (edges !== 255 || bad !== 0) $display("FAIL max_count got edges=%0d bad_steps=%0d exp 255/0", edges, bad); else n_pass++;
`ifdef TIMER_AUTO_RELOAD_EN
    n_checks++; if (value !== 8'd255) $display("FAIL max_reload got=%0d exp=255", value); else n_pass++;
`else
    n_checks++; if (value !== 8'd0) $display("FAIL max_no_wrap got=%0d exp=0", value); else n_pass++;
`endif
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 0, 10);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 10);
    n_checks++; if (value !== 8'd3) $display("FAIL mid_pre got=%0d exp=3", value); else n_pass++;
    step(1, 1, 0, 0, 10);
    n_checks++; if (value !== 8'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0)
      $display("FAIL mid_reset got value=%0d running=%b done=%b expired=%b exp 0/0/0/0", value, running, done, expired);
    else n_pass++;
    step(0, 0, 0, 0, 0);
  endtask

`ifdef TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int bad = 0;
    int pulses = 0;
    step(0, 1, 0, 0, 2);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 0, 2);
      if (expired !== (i % 2 == 0)) bad++;
      if (running !== 1'b1) bad++;
      if (expired === 1'b1) pulses++;
    end
    n_checks++; if (bad !== 0 || pulses !== 10) $display("FAIL auto_reload got bad=%0d pulses=%0d exp 0/10", bad, pulses); else n_pass++;
    step(0, 0, 1, 0, 0);
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    bit r, s, a, h;
    int p;
    step(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      r = ($urandom_range(0, 63) == 0);
      a = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      reset = r; start = s; abort = a; hold = h; period = p[SIZE-1:0];
      #8;
      if (value !== 8'(m_val) || running !== (m_mode == 1) || done !== (m_mode == 2) || expired !== m_exp) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random cyc=%0d got value=%0d running=%b done=%b expired=%b exp value=%0d running=%b done=%b expired=%b",
                   cyc, value, running, done, expired, m_val, (m_mode == 1), (m_mode == 2), m_exp);
      end
      @(posedge clock);
      #1;
      model_step(r, s, a, h, p);
    end
    n_checks++; if (errs !== 0) $display("FAIL random_run got errors=%0d exp=0", errs); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; period = '0;
    m_mode = 0; m_val = 0; m_exp = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_restart_abort();
    test_period_zero();
    test_max();
    test_reset_mid();
`ifdef TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
